// File: rtl/schmidl_cox_frame_ctrl.sv
// Frame-capture controller behind the Schmidl-Cox metric datapath: qualifies a detection,
// forwards packet_size samples framed into SPP-sample packets, then drops a guard interval.
module schmidl_cox_frame_ctrl #(
  parameter int unsigned ITEM_W    = 32,
  parameter int unsigned METRIC_W  = 32,
  parameter int unsigned SIZE_W    = 16,
  parameter int unsigned SPP       = 64,
  parameter int unsigned HOLD_LEN  = 4,
  parameter int unsigned GUARD_LEN = 128
) (
  input  logic                ce_clk,
  input  logic                ce_rst,
  input  logic                enable,
  input  logic [METRIC_W-1:0] threshold,
  input  logic [SIZE_W-1:0]   packet_size,
  input  logic [ITEM_W-1:0]   s_axis_tdata,
  input  logic [METRIC_W-1:0] s_axis_tmetric,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [ITEM_W-1:0]   m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                detect,
  output logic                busy,
  output logic [SIZE_W-1:0]   frame_count
);

  localparam int unsigned HoldW     = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
  localparam int unsigned GuardW    = (GUARD_LEN > 1) ? $clog2(GUARD_LEN) : 1;
  localparam int unsigned GuardLast = (GUARD_LEN > 0) ? GUARD_LEN - 1 : 0;
  localparam bit          HasGuard  = (GUARD_LEN > 0);

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StGuard
  } state_e;

  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [GuardW-1:0]   guard_q, guard_d;
  logic [SIZE_W-1:0]   frame_len_q, frame_len_d;
  logic [SIZE_W-1:0]   sample_q, sample_d;
  logic [SIZE_W-1:0]   spp_q, spp_d;
  logic [SIZE_W-1:0]   frame_count_q, frame_count_d;
  logic                detect_q, detect_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [ITEM_W-1:0]   out_data_q, out_data_d;

  logic accept;
  logic metric_hi;
  logic hold_full;
  logic qualify;
  logic spp_last;
  logic frame_last;

  // Upstream only ever waits on the output register, and only while a frame is being forwarded.
  assign s_axis_tready = (state_q == StCapture) ? (!out_valid_q || m_axis_tready) : 1'b1;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign metric_hi  = (s_axis_tmetric >= threshold);
  assign hold_full  = (hold_q == HoldW'(HOLD_LEN - 1));
  assign qualify    = (state_q == StArmed) && accept && metric_hi && hold_full
                      && (packet_size != '0);
  assign spp_last   = (spp_q == SIZE_W'(SPP - 1));
  assign frame_last = (sample_q == (frame_len_q - 1'b1));

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    guard_d       = guard_q;
    frame_len_d   = frame_len_q;
    sample_d      = sample_q;
    spp_d         = spp_q;
    frame_count_d = frame_count_q;
    detect_d      = 1'b0;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;

    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      StIdle: begin
        hold_d = '0;
        if (enable) begin
          state_d = StArmed;
        end
      end

      StArmed: begin
        if (accept) begin
          if (!metric_hi) begin
            hold_d = '0;
          end else if (hold_full) begin
            // A zero packet_size swallows the detection and restarts qualification.
            hold_d = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        if (qualify) begin
          detect_d    = 1'b1;
          frame_len_d = packet_size;
          sample_d    = '0;
          spp_d       = '0;
          state_d     = StCapture;
        end else if (!enable) begin
          state_d = StIdle;
        end
      end

      StCapture: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = s_axis_tdata;
          out_last_d  = spp_last || frame_last;
          if (frame_last) begin
            frame_count_d = frame_count_q + 1'b1;
            sample_d      = '0;
            spp_d         = '0;
            hold_d        = '0;
            guard_d       = '0;
            if (HasGuard) begin
              state_d = StGuard;
            end else begin
              state_d = enable ? StArmed : StIdle;
            end
          end else begin
            sample_d = sample_q + 1'b1;
            spp_d    = spp_last ? '0 : spp_q + 1'b1;
          end
        end
      end

      StGuard: begin
        if (accept) begin
          if (guard_q == GuardW'(GuardLast)) begin
            guard_d = '0;
            hold_d  = '0;
            state_d = enable ? StArmed : StIdle;
          end else begin
            guard_d = guard_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      guard_q       <= '0;
      frame_len_q   <= '0;
      sample_q      <= '0;
      spp_q         <= '0;
      frame_count_q <= '0;
      detect_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      guard_q       <= guard_d;
      frame_len_q   <= frame_len_d;
      sample_q      <= sample_d;
      spp_q         <= spp_d;
      frame_count_q <= frame_count_d;
      detect_q      <= detect_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;
  assign detect        = detect_q;
  assign busy          = (state_q == StCapture);
  assign frame_count   = frame_count_q;

endmodule

// File: doc/schmidl_cox_frame_ctrl.md
Name: schmidl_cox_frame_ctrl

Overview:
Frame-capture controller placed after the Schmidl-Cox metric datapath inside rfnoc_block_schmidl_cox, in the ce_clk domain. It watches the per-sample detection metric against the threshold register. On a qualified detection it forwards exactly packet_size samples, framed into SPP-sample packets with tlast, then drops a guard interval and re-arms. Samples outside a frame are consumed and discarded, so the upstream datapath never stalls while armed.

Parameters:
ITEM_W, 32, sample width (sc16 I/Q).
METRIC_W, 32, detection metric width (unsigned).
SIZE_W, 16, width of packet_size, frame and SPP counters.
SPP, 64, maximum samples per output packet (tlast boundary); must be >= 1.
HOLD_LEN, 4, consecutive beats with metric >= threshold needed to qualify a detection; must be >= 1.
GUARD_LEN, 128, samples dropped after a frame before re-arming; 0 means immediate re-arm.

Ports:
ce_clk  in  1  block clock, rising edge.
ce_rst  in  1  synchronous reset, active-high.
enable  in  1  arms the detector when high.
threshold  in  METRIC_W  detection threshold (REG_THRESHOLD).
packet_size  in  SIZE_W  samples per captured frame (REG_PACKET_SIZE).
s_axis_tdata  in  ITEM_W  input sample.
s_axis_tmetric  in  METRIC_W  metric aligned to the same beat as s_axis_tdata.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
m_axis_tdata  out  ITEM_W  output sample.
m_axis_tlast  out  1  end of output packet.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
detect  out  1  one-cycle pulse on the beat that qualifies a detection.
busy  out  1  high in CAPTURE.
frame_count  out  SIZE_W  completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, detect=0, busy=0, frame_count=0, state=IDLE, all counters 0.
- A beat is accepted when s_axis_tvalid && s_axis_tready. All counters advance only on accepted beats.
- Output register: a single registered stage. s_axis_tready = !m_axis_tvalid || m_axis_tready in CAPTURE; s_axis_tready = 1 in every other state. Latency from input to output is 1 cycle; no bubbles at full throughput.
- IDLE: drops beats. Moves to ARMED when enable=1. hold_cnt is cleared.
- ARMED: drops beats.
  - An accepted beat with metric >= threshold (unsigned) increments hold_cnt. An accepted beat below threshold clears hold_cnt.
  - When hold_cnt would reach HOLD_LEN and the latched packet_size != 0: pulse detect, latch packet_size into frame_len, clear sample/SPP counters, go to CAPTURE. The qualifying beat itself is dropped; the next accepted beat is frame sample 0.
  - packet_size==0: the detection is ignored, hold_cnt is cleared, state stays ARMED, detect is not pulsed.
  - enable=0: go to IDLE.
- CAPTURE: forwards beats.
  - m_axis_tlast=1 when the SPP counter reaches SPP-1 or on the last frame sample (sample counter == frame_len-1). The final packet may be shorter than SPP.
  - After the last sample is accepted into the output register: frame_count++, then go to GUARD (GUARD_LEN>0) or ARMED/IDLE (GUARD_LEN=0, chosen by enable).
  - Changes to packet_size or threshold during CAPTURE do not affect the current frame.
  - enable=0 does not truncate the frame; it completes.
  - The metric is ignored.
- GUARD: drops GUARD_LEN accepted beats. Then goes to ARMED if enable=1, else IDLE. hold_cnt is cleared on exit.
- busy=1 exactly while state==CAPTURE. The output register may still hold the last beat after leaving CAPTURE; it drains normally. The next frame cannot start until the guard interval ends, so there is no overlap.
- Reset mid-frame: the partial packet is discarded. m_axis_tvalid drops the cycle after reset. No tlast is emitted. frame_count is not incremented.
- Simultaneous events: detection qualification and enable falling on the same beat means detection wins; the frame is captured, then the block returns to IDLE.

Test Plan:
- packet_size=200, threshold=0x02000000, HOLD_LEN=4, SPP=64. 10 low-metric beats, then 4 beats at 0x03000000, then a ramp of 200 samples -> detect pulses on the 4th high beat. Output packets of 64/64/64/8 samples carry ramp values 0..199. tlast is on samples 63, 127, 191, 199. frame_count=1.
- Metric pattern high,high,high,low,high x4 -> no detect after the first 3 high beats. Detect fires only after the 4 consecutive high beats.
- Random m_axis_tready at 25% stall, packet_size=2304 -> all 2304 samples arrive in order. Packet lengths are 36x64. No drops; no samples beyond 2304.
- Metric held high for 500 beats, packet_size=100, GUARD_LEN=128 -> frame 1 captures beats 4..103. Guard drops 104..231. The detector re-arms and detect fires at beat 235. frame_count=2 after the second frame.
- packet_size=0 with metric high -> no detect, busy stays 0. Changing packet_size to 64 mid-CAPTURE of a 200-sample frame -> the frame is still 200 samples.
- ce_rst asserted after 30 samples of a frame -> m_axis_tvalid=0 next cycle, frame_count=0, state IDLE. A new detection after reset yields a correct full frame.
